regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 85 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, defaults and the write-request record for the register-file write-back arbiter.
// Used by regfile_wb_arbiter and, when WB_SCOREBOARD_EN is defined, regfile_scoreboard.
package regfile_wb_arbiter_pkg;
  localparam int REG_W           = 5;
  localparam int DATA_W          = 32;
  localparam int REG_COUNT       = 32;
  localparam int AGE_MAX_DEFAULT = 3;
  localparam int AGE_W           = 4;

  typedef struct packed {
    logic [REG_W-1:0]  regIdx;
    logic [DATA_W-1:0] data;
  } wbReq_t;

  // Register 0 is hard-wired, so writes to it are accepted but never performed.
  function automatic logic isWritable(input logic [REG_W-1:0] r);
    return r != '0;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for long-latency results: one busy bit per register 1..31.
// Latency: busy updates on the next edge, queries are combinational; no backpressure (set wins over clear).
// Only instantiated when WB_SCOREBOARD_EN is defined.
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             BIssue,
  input  logic [REG_W-1:0] BIssueReg,
  input  logic             clrVld,
  input  logic [REG_W-1:0] clrReg,
  input  logic [REG_W-1:0] QReg1,
  input  logic [REG_W-1:0] QReg2,
  output logic             QBusy1,
  output logic             QBusy2
);

  logic [REG_COUNT-1:1] busy;
  logic [REG_COUNT-1:0] setMask, clrMask, busyFull;

  always_comb begin
    setMask  = BIssue ? (REG_COUNT'(1) << BIssueReg) : '0;
    clrMask  = clrVld ? (REG_COUNT'(1) << clrReg) : '0;
    busyFull = {busy, 1'b0};
    QBusy1   = busyFull[QReg1];
    QBusy2   = busyFull[QReg2];
  end

  // Bit 0 of the masks is discarded, so register 0 can never become busy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) busy <= '0;
    else      busy <= (busy & ~clrMask[REG_COUNT-1:1]) | setMask[REG_COUNT-1:1];
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates pipeline (A) and long-latency (B) writes onto the single register-file write port; WB_SCOREBOARD_EN adds a busy scoreboard.
// Latency 1: a transfer appears on RegWre/WriteReg/WriteData at the edge ending the transfer cycle.
// Backpressure: A has priority; B is forced through after AGE_MAX stalled cycles, AReady drops for that slot.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int AGE_MAX = AGE_MAX_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              AValid,
  input  logic [REG_W-1:0]  AReg,
  input  logic [DATA_W-1:0] AData,
  output logic              AReady,
  input  logic              BValid,
  input  logic [REG_W-1:0]  BReg,
  input  logic [DATA_W-1:0] BData,
  output logic              BReady,
  output logic              RegWre,
  output logic [REG_W-1:0]  WriteReg,
  output logic [DATA_W-1:0] WriteData,
  input  logic              BIssue,
  input  logic [REG_W-1:0]  BIssueReg,
  input  logic [REG_W-1:0]  QReg1,
  input  logic [REG_W-1:0]  QReg2,
  output logic              QBusy1,
  output logic              QBusy2
);

  logic [AGE_W-1:0] age, ageNext;
  logic             forceB, aXfer, bXfer, anyXfer;
  wbReq_t           winner;

  always_comb begin
    forceB  = BValid && (age == AGE_W'(AGE_MAX));
    AReady  = !forceB;
    BReady  = forceB || !AValid;
    aXfer   = AValid && AReady;
    bXfer   = BValid && BReady;
    anyXfer = aXfer || bXfer;
    winner  = bXfer ? '{regIdx: BReg, data: BData} : '{regIdx: AReg, data: AData};

    // Age counts only uninterrupted waiting; a gap in BValid restarts it.
    ageNext = age;
    if (!BValid || bXfer)            ageNext = '0;
    else if (age != AGE_W'(AGE_MAX)) ageNext = age + AGE_W'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      age       <= '0;
      RegWre    <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      age    <= ageNext;
      RegWre <= anyXfer && isWritable(winner.regIdx);
      if (anyXfer) begin
        WriteReg  <= winner.regIdx;
        WriteData <= winner.data;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  regfile_scoreboard uScoreboard (
    .CLK       (CLK),
    .RST       (RST),
    .BIssue    (BIssue),
    .BIssueReg (BIssueReg),
    .clrVld    (bXfer),
    .clrReg    (BReg),
    .QReg1     (QReg1),
    .QReg2     (QReg2),
    .QBusy1    (QBusy1),
    .QBusy2    (QBusy2)
  );
`else
  logic unusedSb;
  assign unusedSb = ^{BIssue, BIssueReg, QReg1, QReg2};
  assign QBusy1   = 1'b0;
  assign QBusy2   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset/scoreboard sequences, then randomized traffic against a reference model.
// Inputs change on the falling edge; readies are sampled 1 ns later, the write port 1 ns after the rising edge.
module tb_regfile_wb_arbiter;
  localparam int AGE = 3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        AValid, BValid, AReady, BReady, RegWre, BIssue, QBusy1, QBusy2;
  logic [4:0]  AReg, BReg, WriteReg, BIssueReg, QReg1, QReg2;
  logic [31:0] AData, BData, WriteData;

  int nVec  = 0;
  int nFail = 0;

  always #5 CLK = ~CLK;

  regfile_wb_arbiter #(.AGE_MAX(AGE)) dut (
    .CLK(CLK), .RST(RST),
    .AValid(AValid), .AReg(AReg), .AData(AData), .AReady(AReady),
    .BValid(BValid), .BReg(BReg), .BData(BData), .BReady(BReady),
    .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
    .BIssue(BIssue), .BIssueReg(BIssueReg),
    .QReg1(QReg1), .QReg2(QReg2), .QBusy1(QBusy1), .QBusy2(QBusy2)
  );

  typedef struct {
    bit        av;  logic [4:0] ar; logic [31:0] ad;
    bit        bv;  logic [4:0] br; logic [31:0] bd;
    bit        eAR; bit eBR; bit eWe; bit chkDat;
    logic [4:0] eReg; logic [31:0] eData;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit bv, input logic [4:0] br, input logic [31:0] bd);
    AValid = av; AReg = ar; AData = ad;
    BValid = bv; BReg = br; BData = bd;
  endtask

  vec_t tbl[12];
  bit   forced, eAR, eBR, aX, bX, eWe;
  logic [4:0]  eReg;
  logic [31:0] eData;
  int   waited;
  bit   busyM[32];
  bit   bHold;

  initial begin
    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    BIssue = 0; BIssueReg = 0; QReg1 = 0; QReg2 = 0;
    #1;
    chk("reset RegWre", 32'(RegWre), 0);
    chk("reset WriteReg", 32'(WriteReg), 0);
    chk("reset WriteData", WriteData, 0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1;

    // Directed table: single A, idle hold, dropped B to r0, B only, forced B slot, equal regs, age clear.
    tbl[0]  = '{1,5,32'h12345678, 0,0,0,          1,0,1,1, 5,32'h12345678};
    tbl[1]  = '{0,0,0,            0,0,0,          1,1,0,1, 5,32'h12345678};
    tbl[2]  = '{0,0,0,            1,0,32'hDEADBEEF,1,1,0,0, 0,0};
    tbl[3]  = '{0,0,0,            1,7,32'hCAFE0007,1,1,1,1, 7,32'hCAFE0007};
    tbl[4]  = '{1,1,32'h11110000, 1,2,32'h22220000,1,0,1,1, 1,32'h11110000};
    tbl[5]  = '{1,1,32'h11110000, 1,2,32'h22220000,1,0,1,1, 1,32'h11110000};
    tbl[6]  = '{1,1,32'h11110000, 1,2,32'h22220000,1,0,1,1, 1,32'h11110000};
    tbl[7]  = '{1,1,32'h11110000, 1,2,32'h22220000,0,1,1,1, 2,32'h22220000};
    tbl[8]  = '{1,1,32'h11110000, 1,2,32'h22220000,1,0,1,1, 1,32'h11110000};
    tbl[9]  = '{1,3,32'h33330000, 1,3,32'h44440000,1,0,1,1, 3,32'h33330000};
    tbl[10] = '{1,4,32'h55550000, 0,0,0,          1,0,1,1, 4,32'h55550000};
    tbl[11] = '{0,0,0,            0,0,0,          1,1,0,1, 4,32'h55550000};
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].bv, tbl[i].br, tbl[i].bd);
      #1;
      chk($sformatf("tbl%0d AReady", i), 32'(AReady), 32'(tbl[i].eAR));
      chk($sformatf("tbl%0d BReady", i), 32'(BReady), 32'(tbl[i].eBR));
      @(posedge CLK); #1;
      chk($sformatf("tbl%0d RegWre", i), 32'(RegWre), 32'(tbl[i].eWe));
      if (tbl[i].chkDat) begin
        chk($sformatf("tbl%0d WriteReg", i), 32'(WriteReg), 32'(tbl[i].eReg));
        chk($sformatf("tbl%0d WriteData", i), WriteData, tbl[i].eData);
      end
    end

`ifdef WB_SCOREBOARD_EN
    // Issue r9, then a same-cycle reissue+write keeps it busy, then a plain write clears it.
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0); BIssue = 1; BIssueReg = 9; QReg1 = 9; QReg2 = 0;
    @(negedge CLK);
    BIssue = 0; #1;
    chk("sb busy after issue", 32'(QBusy1), 1);
    chk("sb QReg 0", 32'(QBusy2), 0);
    drive(0, 0, 0, 1, 9, 32'h99);
    BIssue = 1; BIssueReg = 9;
    @(negedge CLK);
    BIssue = 0; drive(0, 0, 0, 0, 0, 0); #1;
    chk("sb set wins", 32'(QBusy1), 1);
    drive(0, 0, 0, 1, 9, 32'h99);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0); #1;
    chk("sb cleared", 32'(QBusy1), 0);
    BIssue = 1; BIssueReg = 9;
    @(negedge CLK);
    BIssue = 0;
`endif

    // Stall B to age 2 with A winning, reset mid-cycle after an accepted write, then expect a full fresh age run.
    @(negedge CLK);
    drive(1, 10, 32'hA0A0A0A0, 1, 11, 32'hB0B0B0B0);
    @(negedge CLK);
    @(posedge CLK); #1;
    chk("pre-reset RegWre", 32'(RegWre), 1);
    #2 RST = 1'b0;
    #1;
    chk("mid reset RegWre", 32'(RegWre), 0);
    chk("mid reset WriteReg", 32'(WriteReg), 0);
    chk("mid reset WriteData", WriteData, 0);
    QReg1 = 9; #1;
    chk("mid reset busy r9", 32'(QBusy1), 0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("post-reset BReady c%0d", i), 32'(BReady), (i == 3) ? 1 : 0);
      chk($sformatf("post-reset AReady c%0d", i), 32'(AReady), (i == 3) ? 0 : 1);
      @(negedge CLK);
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge CLK);

    // Randomized traffic; the model tracks how long B has waited and which regs have writes pending.
    waited = 0; bHold = 0;
    foreach (busyM[k]) busyM[k] = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      AValid = ($urandom_range(9) < 6);
      AReg   = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      AData  = $urandom;
      if (!bHold || $urandom_range(9) == 0) begin
        BValid = ($urandom_range(2) != 0);
        BReg   = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
        BData  = $urandom;
      end
      BIssue    = ($urandom_range(3) == 0);
      BIssueReg = ($urandom_range(3) == 0) ? BReg : 5'($urandom);
      QReg1     = 5'($urandom);
      QReg2     = ($urandom_range(1) == 0) ? BReg : 5'($urandom);
      #1;
      forced = BValid && (waited >= AGE);
      eAR    = !forced;
      eBR    = forced || !AValid;
      chk($sformatf("rnd%0d AReady", i), 32'(AReady), 32'(eAR));
      chk($sformatf("rnd%0d BReady", i), 32'(BReady), 32'(eBR));
`ifdef WB_SCOREBOARD_EN
      chk($sformatf("rnd%0d QBusy1", i), 32'(QBusy1), 32'(busyM[QReg1]));
      chk($sformatf("rnd%0d QBusy2", i), 32'(QBusy2), 32'(busyM[QReg2]));
`else
      chk($sformatf("rnd%0d QBusy1", i), 32'(QBusy1), 0);
      chk($sformatf("rnd%0d QBusy2", i), 32'(QBusy2), 0);
`endif
      aX    = AValid && eAR;
      bX    = BValid && eBR;
      eReg  = bX ? BReg : AReg;
      eData = bX ? BData : AData;
      eWe   = (aX || bX) && (eReg != 0);
      if (bX && BReg != 0) busyM[BReg] = 0;
      if (BIssue && BIssueReg != 0) busyM[BIssueReg] = 1;
      waited = (!BValid || bX) ? 0 : waited + 1;
      bHold  = BValid && !bX;
      @(posedge CLK); #1;
      chk($sformatf("rnd%0d RegWre", i), 32'(RegWre), 32'(eWe));
      if (eWe) begin
        chk($sformatf("rnd%0d WriteReg", i), 32'(WriteReg), 32'(eReg));
        chk($sformatf("rnd%0d WriteData", i), WriteData, eData);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
